// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the byte-enable-less data memory: sub-word stores
// are read-modify-write, sub-word loads are lane-extracted and extended.
// Optional alignment trapping is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_mem_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_misaligned,
    output logic                  mem_en,
    output logic                  rd_wr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH-1:0] write_addr,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RWAIT, S_WR, S_RESP} state_e;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [1:0]            off_q, off_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mem_en_q, mem_en_d;
    logic                  rd_wr_q, rd_wr_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_out_q, wdata_out_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
    logic                  resp_mis_q, resp_mis_d;

    logic [1:0]            req_off_c;
    logic                  req_fault_c;
    logic [7:0]            byte_lane_c;
    logic [15:0]           half_lane_c;
    logic [DATA_WIDTH-1:0] load_ext_c;
    logic [DATA_WIDTH-1:0] merged_c;

    // Effective lane offset and fault decision for the request being presented
    always_comb begin
        req_off_c   = req_addr[1:0];
        req_fault_c = (req_size == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_size == SZ_H) && req_addr[0])
            req_fault_c = 1'b1;
        if ((req_size == SZ_W) && (req_addr[1:0] != 2'b00))
            req_fault_c = 1'b1;
`else
        if (req_size == SZ_H)
            req_off_c = {req_addr[1], 1'b0};
        if (req_size == SZ_W)
            req_off_c = 2'b00;
`endif
    end

    // Lane extract / extend for loads and lane merge for sub-word stores
    always_comb begin
        byte_lane_c = 8'(read_data >> {off_q, 3'b000});
        half_lane_c = 16'(read_data >> {off_q[1], 4'b0000});
        merged_c    = read_data;
        case (size_q)
            SZ_B: begin
                load_ext_c = uns_q ? {{(DATA_WIDTH-8){1'b0}}, byte_lane_c}
                                   : {{(DATA_WIDTH-8){byte_lane_c[7]}}, byte_lane_c};
                merged_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            SZ_H: begin
                load_ext_c = uns_q ? {{(DATA_WIDTH-16){1'b0}}, half_lane_c}
                                   : {{(DATA_WIDTH-16){half_lane_c[15]}}, half_lane_c};
                merged_c[{off_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            default: begin
                load_ext_c = read_data;
                merged_c   = wdata_q;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        raddr_d      = raddr_q;
        waddr_d      = waddr_q;
        wdata_out_d  = wdata_out_q;
        resp_rdata_d = resp_rdata_q;
        resp_mis_d   = resp_mis_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_off_c;
                    wdata_d = req_wdata;
                    if (req_fault_c) begin
                        state_d      = S_RESP;
                        resp_rdata_d = '0;
                        resp_mis_d   = 1'b1;
                    end else begin
                        raddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        waddr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        if (req_we && (req_size == SZ_W)) begin
                            state_d     = S_WR;
                            wdata_out_d = req_wdata;
                        end else begin
                            state_d = S_RD;
                        end
                    end
                end
            end
            S_RD:    state_d = S_RWAIT;
            S_RWAIT: begin
                if (we_q) begin
                    state_d     = S_WR;
                    wdata_out_d = merged_c;
                end else begin
                    state_d      = S_RESP;
                    resp_rdata_d = load_ext_c;
                    resp_mis_d   = 1'b0;
                end
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_rdata_d = '0;
                resp_mis_d   = 1'b0;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        mem_en_d     = (state_d == S_RD) || (state_d == S_WR);
        rd_wr_d      = (state_d == S_WR);
        resp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_en_q     <= 1'b0;
            rd_wr_q      <= 1'b0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            wdata_out_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_en_q     <= mem_en_d;
            rd_wr_q      <= rd_wr_d;
            raddr_q      <= raddr_d;
            waddr_q      <= waddr_d;
            wdata_out_q  <= wdata_out_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
        end
    end

    assign req_ready       = (state_q == S_IDLE);
    assign mem_en          = mem_en_q;
    assign rd_wr           = rd_wr_q;
    assign read_addr       = raddr_q;
    assign write_addr      = waddr_q;
    assign write_data      = wdata_out_q;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;

endmodule
